pc_sequencer: RTL and testbench

//  Fetch-side program counter unit directly upstream of the branch predictor. Owns if_PC, id_PC and exe_PC
//  (halfword addresses), and selects the next PC from the branch-predictor outputs, ID-stage jumps and ISR

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_next_mux.sv | 41 ++++
 rtl/pc_sequencer.sv | 132 +++++++++++++
 tb/tb_pc_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared widths, reset/vector addresses, correction codes and FSM encoding for the PC sequencer.
package pc_pkg;

   localparam int unsigned PC_W = 11;

   localparam logic [PC_W-1:0] RESET_PC = 11'h000;
   localparam logic [PC_W-1:0] ISR_VEC  = 11'h300;

   localparam logic [1:0] CORR_NONE = 2'b00;
   localparam logic [1:0] CORR_CNI  = 2'b10;
   localparam logic [1:0] CORR_PBT  = 2'b11;

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_ISR    = 1'b1
   } seq_state_e;

endpackage : pc_pkg

// File: rtl/pc_next_mux.sv
// Next fetch address: fixed-priority select over redirect sources, falling back to sequential fetch.
module pc_next_mux
   import pc_pkg::*;
(
   input  logic [PC_W-1:0] if_pc_i,
   input  logic            if_is_compressed_i,
   input  logic            sel_pbt_i,
   input  logic            sel_cni_i,
   input  logic            sel_jmp_i,
   input  logic            sel_ret_i,
   input  logic            sel_isr_i,
   input  logic            sel_pred_i,
   input  logic [PC_W-1:0] exe_pbt_i,
   input  logic [PC_W-1:0] exe_cni_i,
   input  logic [PC_W-1:0] id_target_i,
   input  logic [PC_W-1:0] saved_pc_i,
   input  logic [PC_W-1:0] if_pbt_i,
   output logic [PC_W-1:0] next_pc_o
);

   logic [PC_W-1:0] inc_c;
   logic [PC_W-1:0] seq_pc_c;

   // Halfword step: 1 for a 16-bit instruction, 2 for a 32-bit one; wraps modulo 2^PC_W.
   always_comb begin
      inc_c    = if_is_compressed_i ? PC_W'(1) : PC_W'(2);
      seq_pc_c = if_pc_i + inc_c;
   end

   // First matching source wins, EXE corrections first.
   always_comb begin
      next_pc_o = seq_pc_c;
      if (sel_pbt_i)       next_pc_o = exe_pbt_i;
      else if (sel_cni_i)  next_pc_o = exe_cni_i;
      else if (sel_jmp_i)  next_pc_o = id_target_i;
      else if (sel_ret_i)  next_pc_o = saved_pc_i;
      else if (sel_isr_i)  next_pc_o = ISR_VEC;
      else if (sel_pred_i) next_pc_o = if_pbt_i;
   end

endmodule : pc_next_mux

// File: rtl/pc_sequencer.sv
// Fetch-side PC unit: owns IF/ID/EXE PCs and valid bits, and sequences ISR entry/return.
module pc_sequencer
   import pc_pkg::*;
(
   input  logic            CLK,
   input  logic            nrst,
   input  logic            stall,
   input  logic            if_is_compressed,
   input  logic            if_prediction,
   input  logic [PC_W-1:0] if_PBT,
   input  logic            id_is_jump,
   input  logic            id_is_btype,
   input  logic            id_jump_in_bht,
   input  logic [PC_W-1:0] id_branchtarget,
   input  logic            id_is_ret,
   input  logic            exe_is_cti,
   input  logic [1:0]      exe_correction,
   input  logic [PC_W-1:0] exe_PBT,
   input  logic [PC_W-1:0] exe_CNI,
   input  logic            jump_flush,
   input  logic            branch_flush,
   input  logic            int_req,
   output logic            int_ack,
   output logic            ISR_running,
   output logic [PC_W-1:0] if_PC,
   output logic [PC_W-1:0] id_PC,
   output logic [PC_W-1:0] exe_PC,
   output logic            id_valid,
   output logic            exe_valid
);

   seq_state_e      state_q, state_d;
   logic [PC_W-1:0] if_pc_q, id_pc_q, exe_pc_q, saved_pc_q;
   logic            id_valid_q, exe_valid_q, int_ack_q;

   logic            corr_pbt_c, corr_cni_c, id_jmp_c, hi_redirect_c;
   logic            irq_clear_c, isr_entry_c, ret_take_c;
   logic            id_valid_d, exe_valid_d;
   logic [PC_W-1:0] next_pc_c;

   // Redirects that outrank an ISR return or entry.
   always_comb begin
      corr_pbt_c    = (exe_correction == CORR_PBT);
      corr_cni_c    = (exe_correction == CORR_CNI);
      id_jmp_c      = id_is_jump & ~id_jump_in_bht;
      hi_redirect_c = corr_pbt_c | corr_cni_c | id_jmp_c;
      // Entry waits until no control transfer is anywhere in ID/EXE, so saved_pc is a clean resume point.
      irq_clear_c   = ~hi_redirect_c & ~id_is_jump & ~id_is_btype & ~exe_is_cti;
   end

   // FSM state register.
   always_ff @(posedge CLK) begin
      if (!nrst) state_q <= ST_NORMAL;
      else       state_q <= state_d;
   end

   // FSM next state: no nesting; a correction alongside the ret keeps us in ISR.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_NORMAL: if (!stall && int_req && irq_clear_c)       state_d = ST_ISR;
         ST_ISR:    if (!stall && id_is_ret && !hi_redirect_c)  state_d = ST_NORMAL;
         default:                                               state_d = ST_NORMAL;
      endcase
   end

   // FSM outputs: transition strobes steering the PC mux and pipeline kills.
   always_comb begin
      isr_entry_c = 1'b0;
      ret_take_c  = 1'b0;
      case (state_q)
         ST_NORMAL: isr_entry_c = !stall && int_req && irq_clear_c;
         ST_ISR:    ret_take_c  = !stall && id_is_ret && !hi_redirect_c;
         default:   ;
      endcase
   end

   pc_next_mux u_next_mux (
      .if_pc_i            (if_pc_q),
      .if_is_compressed_i (if_is_compressed),
      .sel_pbt_i          (corr_pbt_c),
      .sel_cni_i          (corr_cni_c),
      .sel_jmp_i          (id_jmp_c),
      .sel_ret_i          (ret_take_c),
      .sel_isr_i          (isr_entry_c),
      .sel_pred_i         (if_prediction),
      .exe_pbt_i          (exe_PBT),
      .exe_cni_i          (exe_CNI),
      .id_target_i        (id_branchtarget),
      .saved_pc_i         (saved_pc_q),
      .if_pbt_i           (if_PBT),
      .next_pc_o          (next_pc_c)
   );

   // Slot kills: any redirect originating at or after IF turns the fetched slot into a bubble.
   always_comb begin
      id_valid_d  = ~(branch_flush | jump_flush | isr_entry_c | ret_take_c);
      exe_valid_d = id_valid_q & ~branch_flush;
   end

   // PC, valid and saved-PC registers; stall freezes everything except the ack pulse.
   always_ff @(posedge CLK) begin
      if (!nrst) begin
         if_pc_q     <= RESET_PC;
         id_pc_q     <= '0;
         exe_pc_q    <= '0;
         id_valid_q  <= 1'b0;
         exe_valid_q <= 1'b0;
         saved_pc_q  <= '0;
         int_ack_q   <= 1'b0;
      end else begin
         int_ack_q <= isr_entry_c;
         if (!stall) begin
            if_pc_q     <= next_pc_c;
            id_pc_q     <= if_pc_q;
            exe_pc_q    <= id_pc_q;
            id_valid_q  <= id_valid_d;
            exe_valid_q <= exe_valid_d;
            if (isr_entry_c) saved_pc_q <= if_pc_q;
         end
      end
   end

   assign if_PC       = if_pc_q;
   assign id_PC       = id_pc_q;
   assign exe_PC      = exe_pc_q;
   assign id_valid    = id_valid_q;
   assign exe_valid   = exe_valid_q;
   assign int_ack     = int_ack_q;
   assign ISR_running = (state_q == ST_ISR);

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;
   import pc_pkg::*;

   logic            CLK = 1'b0;
   logic            nrst;
   logic            stall;
   logic            if_is_compressed;
   logic            if_prediction;
   logic [PC_W-1:0] if_PBT;
   logic            id_is_jump;
   logic            id_is_btype;
   logic            id_jump_in_bht;
   logic [PC_W-1:0] id_branchtarget;
   logic            id_is_ret;
   logic            exe_is_cti;
   logic [1:0]      exe_correction;
   logic [PC_W-1:0] exe_PBT;
   logic [PC_W-1:0] exe_CNI;
   logic            jump_flush;
   logic            branch_flush;
   logic            int_req;
   logic            int_ack;
   logic            ISR_running;
   logic [PC_W-1:0] if_PC;
   logic [PC_W-1:0] id_PC;
   logic [PC_W-1:0] exe_PC;
   logic            id_valid;
   logic            exe_valid;

   int checks = 0;
   int errors = 0;

   pc_sequencer dut (
      .CLK              (CLK),
      .nrst             (nrst),
      .stall            (stall),
      .if_is_compressed (if_is_compressed),
      .if_prediction    (if_prediction),
      .if_PBT           (if_PBT),
      .id_is_jump       (id_is_jump),
      .id_is_btype      (id_is_btype),
      .id_jump_in_bht   (id_jump_in_bht),
      .id_branchtarget  (id_branchtarget),
      .id_is_ret        (id_is_ret),
      .exe_is_cti       (exe_is_cti),
      .exe_correction   (exe_correction),
      .exe_PBT          (exe_PBT),
      .exe_CNI          (exe_CNI),
      .jump_flush       (jump_flush),
      .branch_flush     (branch_flush),
      .int_req          (int_req),
      .int_ack          (int_ack),
      .ISR_running      (ISR_running),
      .if_PC            (if_PC),
      .id_PC            (id_PC),
      .exe_PC           (exe_PC),
      .id_valid         (id_valid),
      .exe_valid        (exe_valid)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      stall            = 1'b0;
      if_is_compressed = 1'b0;
      if_prediction    = 1'b0;
      if_PBT           = '0;
      id_is_jump       = 1'b0;
      id_is_btype      = 1'b0;
      id_jump_in_bht   = 1'b0;
      id_branchtarget  = '0;
      id_is_ret        = 1'b0;
      exe_is_cti       = 1'b0;
      exe_correction   = CORR_NONE;
      exe_PBT          = '0;
      exe_CNI          = '0;
      jump_flush       = 1'b0;
      branch_flush     = 1'b0;
      int_req          = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_if_PC"},  32'(if_PC),       32'h0);
      chk({tag, "_id_PC"},  32'(id_PC),       32'h0);
      chk({tag, "_exe_PC"}, 32'(exe_PC),      32'h0);
      chk({tag, "_id_v"},   32'(id_valid),    32'h0);
      chk({tag, "_exe_v"},  32'(exe_valid),   32'h0);
      chk({tag, "_isr"},    32'(ISR_running), 32'h0);
      chk({tag, "_ack"},    32'(int_ack),     32'h0);
   endtask

   initial begin
      clear_inputs();
      nrst = 1'b0;
      tick();
      tick();
      chk_reset("rst");

      // Sequential 32-bit fetch
      nrst = 1'b1;
      tick();
      chk("seq1_if", 32'(if_PC), 32'h2);
      chk("seq1_idv", 32'(id_valid), 32'h1);
      chk("seq1_exv", 32'(exe_valid), 32'h0);
      tick();
      chk("seq2_if", 32'(if_PC), 32'h4);
      chk("seq2_id", 32'(id_PC), 32'h2);
      chk("seq2_exv", 32'(exe_valid), 32'h1);
      tick();
      chk("seq3_if", 32'(if_PC), 32'h6);
      chk("seq3_exe", 32'(exe_PC), 32'h2);
      tick();
      chk("seq4_if", 32'(if_PC), 32'h8);

      // Prediction and compressed step
      if_is_compressed = 1'b1;
      tick();
      chk("cmp_if", 32'(if_PC), 32'h9);
      if_prediction = 1'b1; if_PBT = 11'h008;
      tick();
      chk("pred8_if", 32'(if_PC), 32'h8);
      if_PBT = 11'h040;
      tick();
      chk("pred40_if", 32'(if_PC), 32'h40);

      // EXE correction beats prediction; flush kills ID and EXE slots
      exe_correction = CORR_CNI; exe_CNI = 11'h022; branch_flush = 1'b1;
      tick();
      chk("corr_if", 32'(if_PC), 32'h22);
      chk("corr_idv", 32'(id_valid), 32'h0);
      chk("corr_exv", 32'(exe_valid), 32'h0);
      clear_inputs();
      tick();
      chk("corr2_if", 32'(if_PC), 32'h24);
      chk("corr2_idv", 32'(id_valid), 32'h1);
      chk("corr2_exv", 32'(exe_valid), 32'h0);

      // ID jump not in BHT redirects and kills only the IF slot
      id_is_jump = 1'b1; id_branchtarget = 11'h100; jump_flush = 1'b1;
      tick();
      chk("jmp_if", 32'(if_PC), 32'h100);
      chk("jmp_idv", 32'(id_valid), 32'h0);
      chk("jmp_exv", 32'(exe_valid), 32'h1);
      // Jump already in BHT: no redirect from ID
      jump_flush = 1'b0; id_jump_in_bht = 1'b1; id_branchtarget = 11'h200;
      tick();
      chk("jmpbht_if", 32'(if_PC), 32'h102);
      clear_inputs();

      // Interrupt deferred by a branch in ID, taken once clear
      if_prediction = 1'b1; if_PBT = 11'h04E;
      tick();
      chk("pre_irq_if", 32'(if_PC), 32'h4E);
      clear_inputs();
      int_req = 1'b1; id_is_btype = 1'b1;
      tick();
      chk("irq_def_if", 32'(if_PC), 32'h50);
      chk("irq_def_ack", 32'(int_ack), 32'h0);
      chk("irq_def_isr", 32'(ISR_running), 32'h0);
      id_is_btype = 1'b0;
      tick();
      chk("irq_if", 32'(if_PC), 32'h300);
      chk("irq_ack", 32'(int_ack), 32'h1);
      chk("irq_isr", 32'(ISR_running), 32'h1);
      chk("irq_idv", 32'(id_valid), 32'h0);
      tick();
      chk("irq_nest_if", 32'(if_PC), 32'h302);
      chk("irq_nest_ack", 32'(int_ack), 32'h0);
      chk("irq_nest_isr", 32'(ISR_running), 32'h1);
      int_req = 1'b0;

      // Ret with a correction in EXE: correction wins, stay in ISR
      id_is_ret = 1'b1; exe_correction = CORR_PBT; exe_PBT = 11'h310;
      tick();
      chk("retcorr_if", 32'(if_PC), 32'h310);
      chk("retcorr_isr", 32'(ISR_running), 32'h1);
      exe_correction = CORR_NONE;
      tick();
      chk("ret_if", 32'(if_PC), 32'h50);
      chk("ret_isr", 32'(ISR_running), 32'h0);
      chk("ret_idv", 32'(id_valid), 32'h0);
      // Ret outside ISR is a plain fall-through
      tick();
      chk("retnorm_if", 32'(if_PC), 32'h52);
      chk("retnorm_isr", 32'(ISR_running), 32'h0);
      clear_inputs();

      // Stall holds everything despite a pending correction and interrupt
      stall = 1'b1; exe_correction = CORR_PBT; exe_PBT = 11'h123; int_req = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("stall_if", 32'(if_PC), 32'h52);
      chk("stall_id", 32'(id_PC), 32'h50);
      chk("stall_ack", 32'(int_ack), 32'h0);
      chk("stall_isr", 32'(ISR_running), 32'h0);
      clear_inputs();

      // Wrap at top of address space
      if_prediction = 1'b1; if_PBT = 11'h7FF;
      tick();
      chk("pre_wrap_if", 32'(if_PC), 32'h7FF);
      if_prediction = 1'b0;
      tick();
      chk("wrap_if", 32'(if_PC), 32'h001);

      // Reset in the middle of an ISR overrides stall and redirects
      int_req = 1'b1;
      tick();
      chk("irq2_isr", 32'(ISR_running), 32'h1);
      chk("irq2_if", 32'(if_PC), 32'h300);
      int_req = 1'b0;
      tick();
      nrst = 1'b0; stall = 1'b1; exe_correction = CORR_PBT; exe_PBT = 11'h155;
      tick();
      chk_reset("rst2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pc_sequencer
